// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-in, serial-out word serializer with a one-word hold buffer
module word_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdr,
   output logic             shift_en,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] sreg;
   logic             hold_full;
   logic [CW-1:0]    cnt;
   logic             active;
   logic             last;
   logic             load;
   logic             accept;

   assign active = (state == SHIFT);
   assign last   = active && (cnt == CNT_LAST);
   // The hold buffer reloads the shifter on the last bit, so words stream without a gap.
   assign load   = hold_full && (!active || last);
   assign accept = din_valid && !hold_full;

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         sreg      <= '0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
         end
         if (load) begin
            sreg      <= hold;
            cnt       <= '0;
            state     <= SHIFT;
            hold_full <= 1'b0;
         end else if (active) begin
            sreg <= sreg >> 1;
            cnt  <= cnt + CW'(1);
            if (last) begin
               state <= IDLE;
            end
         end
      end
   end

   assign din_ready = !hold_full;
   assign sdr       = active ? sreg[0] : 1'b0;
   assign shift_en  = active;
   assign word_done = last;
   assign busy      = active || hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - scoreboard bench for word_serializer at WIDTH=4 and WIDTH=8
module tb_word_serializer;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] din4;
   logic       dv4, rdy4, sdr4, se4, wd4, busy4;
   logic [7:0] din8;
   logic       dv8, rdy8, sdr8, se8, wd8, busy8;

   int checks = 0;
   int errors = 0;

   logic [1:0] bq4[$];
   logic [1:0] bq8[$];
   logic [3:0] wq4[$];
   logic [7:0] wq8[$];
   logic [3:0] dq4 = '0;
   logic [7:0] dq8 = '0;
   logic [1:0] e4, e8;
   int run4 = 0;
   int maxrun4 = 0;
   int w;

   word_serializer #(.WIDTH(4)) dut4 (
      .clk(clk), .clr(clr), .din(din4), .din_valid(dv4), .din_ready(rdy4),
      .sdr(sdr4), .shift_en(se4), .word_done(wd4), .busy(busy4)
   );

   word_serializer #(.WIDTH(8)) dut8 (
      .clk(clk), .clr(clr), .din(din8), .din_valid(dv8), .din_ready(rdy8),
      .sdr(sdr8), .shift_en(se8), .word_done(wd8), .busy(busy8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream right-shift register models, serial bit enters the MSB.
   always @(posedge clk) begin
      if (se4) dq4 <= {sdr4, dq4[3:1]};
      if (se8) dq8 <= {sdr8, dq8[7:1]};
   end

   always @(negedge clk) begin
      if (se4) begin
         if (bq4.size() == 0) begin
            chk("bit4_unexpected", 32'(se4), 32'd0);
         end else begin
            e4 = bq4.pop_front();
            chk("bit4_done_sdr", 32'({wd4, sdr4}), 32'(e4));
         end
         if (wd4) begin
            if (wq4.size() == 0) chk("word4_unexpected", 32'(wd4), 32'd0);
            else chk("word4_downstream", 32'({sdr4, dq4[3:1]}), 32'(wq4.pop_front()));
         end
         run4++;
         if (run4 > maxrun4) maxrun4 = run4;
      end else begin
         chk("idle4_outputs", 32'({wd4, sdr4}), 32'd0);
         run4 = 0;
      end
   end

   always @(negedge clk) begin
      if (se8) begin
         if (bq8.size() == 0) begin
            chk("bit8_unexpected", 32'(se8), 32'd0);
         end else begin
            e8 = bq8.pop_front();
            chk("bit8_done_sdr", 32'({wd8, sdr8}), 32'(e8));
         end
         if (wd8) begin
            if (wq8.size() == 0) chk("word8_unexpected", 32'(wd8), 32'd0);
            else chk("word8_downstream", 32'({sdr8, dq8[7:1]}), 32'(wq8.pop_front()));
         end
      end else begin
         chk("idle8_outputs", 32'({wd8, sdr8}), 32'd0);
      end
   end

   task automatic send4(input logic [3:0] word, input bit keep, output int waits);
      din4  = word;
      dv4   = 1'b1;
      waits = 0;
      while (!rdy4 && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      chk("send4_ready", 32'(rdy4), 32'd1);
      @(posedge clk);
      for (int i = 0; i < 4; i++) bq4.push_back({(i == 3) ? 1'b1 : 1'b0, word[i]});
      wq4.push_back(word);
      @(negedge clk);
      if (!keep) dv4 = 1'b0;
   endtask

   task automatic send8(input logic [7:0] word);
      int waits = 0;
      din8 = word;
      dv8  = 1'b1;
      while (!rdy8 && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      chk("send8_ready", 32'(rdy8), 32'd1);
      @(posedge clk);
      for (int i = 0; i < 8; i++) bq8.push_back({(i == 7) ? 1'b1 : 1'b0, word[i]});
      wq8.push_back(word);
      @(negedge clk);
      dv8 = 1'b0;
   endtask

   task automatic drain;
      int n = 0;
      while ((bq4.size() != 0 || bq8.size() != 0 || busy4 || busy8) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(bq4.size() + bq8.size() + wq4.size() + wq8.size()), 32'd0);
      chk("drain_busy", 32'({busy4, busy8}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clr  = 1'b1;
      din4 = 4'hF;
      dv4  = 1'b1;
      din8 = '0;
      dv8  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_din_ready", 32'(rdy4), 32'd1);
      chk("rst_shift_en", 32'(se4), 32'd0);
      chk("rst_sdr", 32'(sdr4), 32'd0);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_busy8", 32'(busy8), 32'd0);
      dv4 = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      chk("rst_no_accept", 32'(busy4), 32'd0);

      // Single word: loaded one edge after acceptance.
      send4(4'b1011, 1'b0, w);
      chk("lat_shift_en_before_load", 32'(se4), 32'd0);
      chk("lat_busy_hold", 32'(busy4), 32'd1);
      chk("lat_ready_low", 32'(rdy4), 32'd0);
      @(negedge clk);
      chk("lat_shift_en_after_load", 32'(se4), 32'd1);
      chk("lat_ready_after_load", 32'(rdy4), 32'd1);
      drain();

      // Back-to-back stream with din_valid held high.
      maxrun4 = 0;
      send4(4'hA, 1'b1, w);
      chk("b2b_wait_a", 32'(w), 32'd0);
      send4(4'h5, 1'b1, w);
      chk("b2b_wait_5", 32'(w), 32'd1);
      send4(4'hC, 1'b0, w);
      chk("b2b_wait_c", 32'(w), 32'd3);
      drain();
      chk("b2b_shift_run", 32'(maxrun4), 32'd12);

      // Backpressure: shifter busy and hold full when 4'h3 arrives.
      send4(4'h6, 1'b1, w);
      send4(4'h9, 1'b1, w);
      send4(4'h3, 1'b0, w);
      chk("bp_wait_3", 32'(w), 32'd3);
      drain();

      // Reset during bit 2 of 4'h9 with 4'h6 in hold.
      send4(4'h9, 1'b1, w);
      send4(4'h6, 1'b0, w);
      @(negedge clk);
      chk("mid_shift_en", 32'(se4), 32'd1);
      chk("mid_hold_full", 32'(rdy4), 32'd0);
      clr = 1'b1;
      @(negedge clk);
      chk("mid_clr_shift_en", 32'(se4), 32'd0);
      chk("mid_clr_busy", 32'(busy4), 32'd0);
      chk("mid_clr_ready", 32'(rdy4), 32'd1);
      bq4.delete();
      wq4.delete();
      clr = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_no_resume", 32'(busy4), 32'd0);

      // WIDTH=8 instance.
      send8(8'h81);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
